// File: rtl/fifo_read_scheduler_if.sv
// FIFO read port and popped-pixel output of the read scheduler.
// The master side is the scheduler; the slave side is the FIFO plus the pixel consumer.
interface fifo_read_scheduler_if;
  logic        empty_fifo;
  logic [16:0] din;
  logic        rd_en;
  logic        pix_valid;
  logic [15:0] pix_data;

  modport master (input empty_fifo, din, output rd_en, pix_valid, pix_data);
  modport slave  (output empty_fifo, din, input rd_en, pix_valid, pix_data);
endinterface

// File: rtl/fifo_read_scheduler.sv
// Pops a first-word-fall-through pixel FIFO in step with the display timing.
// It hunts for the frame marker at the origin and locks after ALIGN_FRAMES clean frames.
module fifo_read_scheduler #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int ALIGN_FRAMES = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sobel,
  input  logic                         blank,
  input  logic [11:0]                  pixel_x,
  input  logic [11:0]                  pixel_y,
  fifo_read_scheduler_if.master        fifo,
  output logic                         aligned,
  output logic [7:0]                   underflow_cnt,
  output logic [1:0]                   state
);

  localparam int CNT_RAW = $clog2(ALIGN_FRAMES + 1);
  localparam int CNT_W   = (CNT_RAW > 3) ? CNT_RAW : 3;
  localparam logic [CNT_W-1:0] ALIGN_MAX = CNT_W'(ALIGN_FRAMES);
  localparam logic [11:0]      X_LAST    = 12'(H_ACTIVE - 1);
  localparam logic [11:0]      Y_LAST    = 12'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    WAIT_BLANK = 2'd0,
    WAIT_SOF   = 2'd1,
    STREAM     = 2'd2,
    LOCKED     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] align_cnt, align_cnt_d;
  logic             aligned_d;
  logic             starved, starved_d;
  logic             sobel_q;
  logic             rd_en_d, pop_valid, count_under;
  logic             is_marker, at_origin, frame_end, mode_change;

  // Bit 16 of the FIFO word has no meaning for scheduling.
  logic unused_din;
  assign unused_din = fifo.din[16];

  assign is_marker   = sobel ? (fifo.din[8] && (fifo.din[15:9] == 7'd0))
                             : (fifo.din[15:0] == 16'h001F);
  assign at_origin   = (pixel_x == 12'd0) && (pixel_y == 12'd0);
  assign frame_end   = (pixel_x == X_LAST) && (pixel_y == Y_LAST) && !blank;
  assign mode_change = (sobel != sobel_q);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d     = state_q;
    align_cnt_d = align_cnt;
    aligned_d   = aligned;
    starved_d   = starved;
    rd_en_d     = 1'b0;
    pop_valid   = 1'b0;
    count_under = 1'b0;

    if (mode_change) begin
      // A display-mode switch invalidates the stream: re-hunt with the new marker.
      state_d     = WAIT_SOF;
      align_cnt_d = '0;
      aligned_d   = 1'b0;
      starved_d   = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_BLANK: begin
          if (blank) state_d = WAIT_SOF;
        end
        WAIT_SOF: begin
          if (!fifo.empty_fifo) begin
            if (!is_marker) begin
              rd_en_d = 1'b1;             // flush junk, never shown
            end else if (at_origin) begin
              rd_en_d   = 1'b1;
              pop_valid = 1'b1;
              state_d   = STREAM;
              if (align_cnt != ALIGN_MAX) align_cnt_d = align_cnt + CNT_W'(1);
            end
          end
        end
        STREAM, LOCKED: begin
          rd_en_d     = !blank && !fifo.empty_fifo;
          pop_valid   = rd_en_d;
          count_under = !blank && fifo.empty_fifo;
          starved_d   = starved || count_under;
          if (frame_end) begin
            if (starved_d) begin
              state_d     = WAIT_SOF;
              align_cnt_d = '0;
              aligned_d   = 1'b0;
              starved_d   = 1'b0;
            end else if (state_q == STREAM) begin
              if (align_cnt == ALIGN_MAX) begin
                state_d   = LOCKED;
                aligned_d = 1'b1;
              end else begin
                state_d = WAIT_SOF;
              end
            end
          end
        end
        default: state_d = WAIT_BLANK;
      endcase
    end
  end

  assign fifo.rd_en = rst_n && rd_en_d;
  assign state      = state_q;

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q        <= WAIT_BLANK;
      align_cnt      <= '0;
      aligned        <= 1'b0;
      starved        <= 1'b0;
      sobel_q        <= sobel;
      underflow_cnt  <= 8'd0;
      fifo.pix_valid <= 1'b0;
      fifo.pix_data  <= 16'd0;
    end else begin
      state_q        <= state_d;
      align_cnt      <= align_cnt_d;
      aligned        <= aligned_d;
      starved        <= starved_d;
      sobel_q        <= sobel;
      fifo.pix_valid <= pop_valid;
      if (pop_valid) fifo.pix_data <= fifo.din[15:0];
      if (count_under && (underflow_cnt != 8'hFF)) underflow_cnt <= underflow_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Directed bench for fifo_read_scheduler on a shrunken 8x4 raster with a queue-based FIFO model.
module tb_fifo_read_scheduler;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int HB = 2;
  localparam int VB = 2;
  localparam int AF = 5;

  logic        clk = 1'b0;
  logic        rst_n, sobel, blank;
  logic [11:0] pixel_x, pixel_y;
  logic        aligned;
  logic [7:0]  underflow_cnt;
  logic [1:0]  state;

  fifo_read_scheduler_if fi ();

  fifo_read_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .ALIGN_FRAMES(AF)) dut (
    .clk(clk), .rst_n(rst_n), .sobel(sobel), .blank(blank),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .fifo(fi.master),
    .aligned(aligned), .underflow_cnt(underflow_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [16:0] q[$];
  bit          force_empty = 1'b0;
  int          npop, nvalid, nviol;
  logic        last_rd;

  task automatic pos(input int x, input int y, input bit b);
    pixel_x = 12'(x);
    pixel_y = 12'(y);
    blank   = b;
  endtask

  // One clock: drive FIFO view, sample rd_en before the edge, pop the model after it.
  task automatic tick(input bit use_q);
    if (use_q) begin
      fi.empty_fifo = force_empty || (q.size() == 0);
      fi.din        = (q.size() != 0) ? q[0] : 17'h0;
    end
    #1;
    last_rd = fi.rd_en;
    if (last_rd === 1'b1 && fi.empty_fifo === 1'b1) nviol++;
    @(posedge clk);
    #1;
    if (use_q && last_rd === 1'b1 && !fi.empty_fifo && q.size() != 0) begin
      void'(q.pop_front());
      npop++;
    end
    if (fi.pix_valid === 1'b1) nvalid++;
  endtask

  int          lead_pops, lead_valid, vis_pops;
  logic [1:0]  st_lead, st_origin;
  logic [15:0] pd_origin, pd_last;

  task automatic run_frame(input logic [16:0] first, input int lead, input int junk,
                           input int sf, input int sl);
    for (int j = 0; j < junk; j++) q.push_back(17'h00A00 + 17'(j));
    q.push_back(first);
    for (int i = 1; i < H * V; i++) q.push_back(17'h01000 + 17'(i));
    npop = 0; nvalid = 0; nviol = 0;
    for (int k = 0; k < lead; k++) begin
      pos(H, V, 1'b1);
      tick(1'b1);
    end
    lead_pops  = npop;
    lead_valid = nvalid;
    st_lead    = state;
    for (int y = 0; y < V + VB; y++) begin
      for (int x = 0; x < H + HB; x++) begin
        bit vis;
        int idx;
        vis = (x < H) && (y < V);
        idx = y * H + x;
        pos(x, y, !vis);
        force_empty = vis && (idx >= sf) && (idx < sf + sl);
        tick(1'b1);
        if (x == 0 && y == 0) begin
          st_origin = state;
          pd_origin = fi.pix_data;
        end
        if (x == H - 1 && y == V - 1) vis_pops = npop - lead_pops;
      end
    end
    force_empty = 1'b0;
    pd_last     = fi.pix_data;
  endtask

  task automatic align_run(input logic [16:0] mk, input int junk0, input string tag);
    for (int f = 1; f <= AF; f++) begin
      run_frame(mk, (f == 1) ? 8 : 2, (f == 1) ? junk0 : 0, 1000, 0);
      if (f == 1 && junk0 > 0) begin
        check({tag, " flush pops"}, lead_pops, junk0);
        check({tag, " flush no valid"}, lead_valid, 0);
        check({tag, " marker held"}, st_lead, 2'd1);
      end
      check({tag, " origin state"}, st_origin, 2'd2);
      check({tag, " origin data"}, pd_origin, mk[15:0]);
      check({tag, " frame pops"}, vis_pops, H * V);
      check({tag, " frame valids"}, nvalid, H * V);
      check({tag, " last data"}, pd_last, 16'h1000 + 16'(H * V - 1));
      check({tag, " end state"}, state, (f == AF) ? 2'd3 : 2'd1);
      check({tag, " aligned"}, aligned, (f == AF) ? 1'b1 : 1'b0);
    end
  endtask

  typedef struct {
    bit          sob;
    bit          emp;
    logic [16:0] d;
    int          x;
    int          y;
    bit          rd;
    bit          pv;
    logic [1:0]  st;
    logic [15:0] pd;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // WAIT_SOF decode vectors: marker detection per mode, hold, flush, mode-switch override.
    tbl[0]  = '{1'b0, 1'b0, 17'h00005, 3, 0, 1'b1, 1'b0, 2'd1, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 17'h1001F, 3, 0, 1'b0, 1'b0, 2'd1, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 17'h0001F, 0, 1, 1'b0, 1'b0, 2'd1, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 17'h00005, 4, 1, 1'b0, 1'b0, 2'd1, 16'h0000};
    tbl[4]  = '{1'b0, 1'b0, 17'h00100, 5, 1, 1'b1, 1'b0, 2'd1, 16'h0000};
    tbl[5]  = '{1'b1, 1'b0, 17'h0001F, 5, 1, 1'b0, 1'b0, 2'd1, 16'h0000};
    tbl[6]  = '{1'b1, 1'b0, 17'h00100, 2, 2, 1'b0, 1'b0, 2'd1, 16'h0000};
    tbl[7]  = '{1'b1, 1'b0, 17'h0001F, 2, 2, 1'b1, 1'b0, 2'd1, 16'h0000};
    tbl[8]  = '{1'b1, 1'b0, 17'h00300, 2, 2, 1'b1, 1'b0, 2'd1, 16'h0000};
    tbl[9]  = '{1'b1, 1'b0, 17'h101FF, 1, 0, 1'b0, 1'b0, 2'd1, 16'h0000};
    tbl[10] = '{1'b0, 1'b0, 17'h0001F, 0, 0, 1'b0, 1'b0, 2'd1, 16'h0000};
    tbl[11] = '{1'b0, 1'b0, 17'h1001F, 0, 0, 1'b1, 1'b1, 2'd2, 16'h001F};

    // Reset with inputs that would otherwise look like a marker at the origin.
    rst_n = 1'b0; sobel = 1'b0;
    pos(0, 0, 1'b0);
    fi.empty_fifo = 1'b0;
    fi.din        = 17'h0001F;
    tick(1'b0);
    tick(1'b0);
    check("reset rd_en", last_rd, 1'b0);
    check("reset state", state, 2'd0);
    check("reset pix_valid", fi.pix_valid, 1'b0);
    check("reset pix_data", fi.pix_data, 16'h0);
    check("reset aligned", aligned, 1'b0);
    check("reset underflow", underflow_cnt, 8'd0);

    rst_n = 1'b1;
    pos(H, V, 1'b1);
    tick(1'b0);
    check("wait_blank rd_en", last_rd, 1'b0);
    check("blank to wait_sof", state, 2'd1);

    for (int i = 0; i < 12; i++) begin
      sobel         = tbl[i].sob;
      fi.empty_fifo = tbl[i].emp;
      fi.din        = tbl[i].d;
      pos(tbl[i].x, tbl[i].y, 1'b0);
      tick(1'b0);
      check($sformatf("vec%0d rd_en", i), last_rd, tbl[i].rd);
      check($sformatf("vec%0d pix_valid", i), fi.pix_valid, tbl[i].pv);
      check($sformatf("vec%0d state", i), state, tbl[i].st);
      check($sformatf("vec%0d pix_data", i), fi.pix_data, tbl[i].pd);
    end

    // Reset while streaming a visible pixel must block the pop and clear the output.
    rst_n = 1'b0;
    fi.empty_fifo = 1'b0;
    fi.din        = 17'h00042;
    pos(2, 0, 1'b0);
    tick(1'b0);
    check("midframe reset rd_en", last_rd, 1'b0);
    check("midframe reset state", state, 2'd0);
    check("midframe reset pix_valid", fi.pix_valid, 1'b0);
    check("midframe reset pix_data", fi.pix_data, 16'h0);
    rst_n = 1'b1;

    align_run(17'h0001F, 3, "rgb");

    // Locked frame whose first word is not a marker still streams.
    run_frame(17'h00055, 2, 0, 1000, 0);
    check("locked origin state", st_origin, 2'd3);
    check("locked frame pops", vis_pops, H * V);
    check("locked end state", state, 2'd3);
    check("locked aligned", aligned, 1'b1);

    // Mode switch while locked, mid-line with data available.
    sobel = 1'b1;
    q.push_back(17'h00077);
    pos(3, 1, 1'b0);
    tick(1'b1);
    check("mode switch rd_en", last_rd, 1'b0);
    check("mode switch state", state, 2'd1);
    check("mode switch aligned", aligned, 1'b0);
    run_frame(17'h00100, 4, 0, 1000, 0);
    check("sobel origin state", st_origin, 2'd2);
    check("sobel origin data", pd_origin, 16'h0100);
    check("sobel end state", state, 2'd1);

    // Ten starved visible pixels in STREAM.
    run_frame(17'h00100, 2, 0, 5, 10);
    check("starve origin state", st_origin, 2'd2);
    check("starve underflow", underflow_cnt, 8'd10);
    check("starve rd_en while empty", nviol, 0);
    check("starve pops", vis_pops, H * V - 10);
    check("starve valids", nvalid, H * V - 10);
    check("starve end state", state, 2'd1);
    check("starve aligned", aligned, 1'b0);

    // Starvation restarted the alignment count: lock needs a full run again.
    align_run(17'h00100, 0, "sobel");

    // Long starvation saturates the counter without leaving LOCKED.
    nviol       = 0;
    force_empty = 1'b1;
    pos(1, 1, 1'b0);
    for (int k = 0; k < 300; k++) tick(1'b1);
    force_empty = 1'b0;
    check("saturate underflow", underflow_cnt, 8'd255);
    check("saturate rd_en while empty", nviol, 0);
    check("saturate state", state, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_read_scheduler.md
FIFO_READ_SCHEDULER -- requirements
Module: fifo_read_scheduler

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter ALIGN_FRAMES, default 5, consecutive marker-aligned frames required before lock.
REQ-004 SHALL have port clk  in  1  pixel clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-006 SHALL have port sobel  in  1  display mode (1 = edge/grayscale, 0 = RGB565).
REQ-007 SHALL have port blank  in  1  timing generator blanking (1 = outside visible area).
REQ-008 SHALL have port pixel_x  in  12  current horizontal count.
REQ-009 SHALL have port pixel_y  in  12  current vertical count.
REQ-010 SHALL have port empty_fifo  in  1  async FIFO empty.
REQ-011 SHALL have port din  in  17  FIFO head word, first-word-fall-through, valid while empty_fifo=0.
REQ-012 SHALL have port rd_en  out  1  FIFO pop, combinational from registered state and inputs.
REQ-013 SHALL have port pix_valid  out  1  pix_data holds a popped word.
REQ-014 SHALL have port pix_data  out  16  pixel word to colour/threshold stage.
REQ-015 SHALL have port aligned  out  1  stream locked to frame markers.
REQ-016 SHALL have port underflow_cnt  out  8  saturating count of starved visible pixels.
REQ-017 SHALL have port state  out  2  current FSM state, for debug.

Function
REQ-018 SHALL define the marker as din[15:0]==16'h001F when sobel=0, and din[8]=1 with din[15:9]=0 when sobel=1.
REQ-019 SHALL define origin as pixel_x==0 and pixel_y==0; frame end as pixel_x==H_ACTIVE-1, pixel_y==V_ACTIVE-1, blank=0.
REQ-020 SHALL implement states WAIT_BLANK=0, WAIT_SOF=1, STREAM=2, LOCKED=3.
REQ-021 WAIT_BLANK: rd_en=0; blank=1 -> WAIT_SOF next cycle.
REQ-022 WAIT_SOF, FIFO non-empty and head not marker: rd_en=1 (flush), no pix_valid.
REQ-023 WAIT_SOF, head is marker, not origin: rd_en=0 (hold marker).
REQ-024 WAIT_SOF, head is marker, at origin: rd_en=1; -> STREAM; align_cnt increments.
REQ-025 STREAM/LOCKED: rd_en = !blank && !empty_fifo.
REQ-026 STREAM/LOCKED, blank=0 and empty_fifo=1: underflow_cnt +1, saturating at 255; frame flagged starved.
REQ-027 STREAM at frame end, not starved: align_cnt==ALIGN_FRAMES -> LOCKED with aligned=1; else -> WAIT_SOF.
REQ-028 LOCKED at frame end: stays LOCKED; marker is not re-checked.
REQ-029 STREAM/LOCKED at frame end, starved: -> WAIT_SOF; align_cnt=0; aligned=0; starved flag cleared.
REQ-030 SHALL register sobel each cycle as sobel_q.
REQ-031 sobel!=sobel_q in any state: -> WAIT_SOF, align_cnt=0, aligned=0, rd_en=0 that cycle; overrides REQ-021..029.
REQ-032 Every cycle with rd_en=1: next cycle pix_valid=1, pix_data=din[15:0] (latency 1); otherwise pix_valid=0 and pix_data holds.
REQ-033 Flush pops (REQ-022) SHALL NOT assert pix_valid.
REQ-034 align_cnt SHALL be 3 bits minimum, width ceil(log2(ALIGN_FRAMES+1)), never exceeding ALIGN_FRAMES.
REQ-035 underflow_cnt SHALL clear only on reset.

Reset
REQ-036 rst_n=0 at a clk edge: state=WAIT_BLANK, pix_valid=0, pix_data=0, aligned=0, underflow_cnt=0, align_cnt=0, starved=0, sobel_q=sobel.
REQ-037 rst_n=0 SHALL force rd_en=0 combinationally; reset mid-frame discards in-flight alignment with no pop.

Verification
REQ-038 Reset, then blank=1 -> state 0->1; FIFO head 16'h001F, sobel=0, at origin -> rd_en=1, next cycle pix_valid=1, pix_data=16'h001F, state=2.
REQ-039 WAIT_SOF with 3 junk words ahead of marker -> three flush pops, pix_valid stays 0, marker held until origin.
REQ-040 5 clean 640x480 frames from reset -> aligned=1 after 5th frame end, state=3, 307200 pops per frame.
REQ-041 empty_fifo=1 for 10 visible pixels in STREAM -> underflow_cnt=10, rd_en=0 those cycles, frame end -> state=1, aligned=0.
REQ-042 Toggle sobel while LOCKED -> next cycle state=1, aligned=0; sobel marker (din=17'h00100) at origin resumes STREAM.
REQ-043 Force 300 starved pixels -> underflow_cnt saturates at 255.
